fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage: owns the PC, drives the instruction memory address and
//   captures the returned word into the IF/ID pipeline register with valid/ready handshake.
//   Sits directly upstream of the combinational instruction memory (word data returned same
//   cycle) and feeds the decode stage; accepts branch/jump redirects from later stages.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC loaded on reset
//   MEM_DEPTH  256            instruction words in memory; (pc>>2) >= MEM_DEPTH is out of range
// PORTS
//   clk             in   1   clock, rising edge
//   reset           in   1   asynchronous, active-high reset
//   imem_addr       out  32  byte address to instruction memory (== pc, combinational)
//   imem_data       in   32  instruction word from memory, valid same cycle
//   redirect_valid  in   1   branch/jump taken this cycle
//   redirect_pc     in   32  redirect target (bits [1:0] forced to 0)
//   id_ready        in   1   decode accepts IF/ID contents this cycle
//   if_id_valid     out  1   IF/ID register holds a real instruction
//   if_id_instr     out  32  latched instruction (32'h0000_0000 = NOP when invalid)
//   if_id_pc        out  32  PC of latched instruction
//   if_id_pc4       out  32  if_id_pc + 4 (mod 2^32)
//   halted          out  1   fetch stopped (PC out of range)
//   fetch_count     out  32  instructions delivered into IF/ID, saturating
// BEHAVIOUR
//   Reset (async, immediate): pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_instr=0,
//     if_id_pc=0, if_id_pc4=0, halted=0, fetch_count=0.
//   States: BOOT -> RUN (unconditional, 1 cycle, no fetch); RUN -> HALTED when advancing with
//     (pc>>2) >= MEM_DEPTH; HALTED -> RUN only on redirect_valid; else hold.
//   advance = !if_id_valid || id_ready  (IF/ID empty or being consumed).
//   Priority per edge: reset > redirect > advance > hold.
//   Redirect (any state except during reset): pc <= {redirect_pc[31:2],2'b00};
//     if_id_valid <= 0, if_id_instr <= 0 (flush wrong path), regardless of id_ready.
//     Current imem_data discarded. First redirected word appears in IF/ID next cycle+1.
//   RUN, advance, pc in range: if_id_instr<=imem_data, if_id_pc<=pc, if_id_pc4<=pc+4,
//     if_id_valid<=1, pc<=pc+4, fetch_count++ (sticks at 32'hFFFF_FFFF).
//   RUN, advance, pc out of range: if_id_valid<=0, if_id_instr<=0, state<=HALTED; pc holds.
//   RUN, !advance (stall): pc and all IF/ID outputs hold bit-exact.
//   HALTED: halted=1 (registered, asserted cycle after entry); IF/ID drains: once consumed
//     (id_ready) if_id_valid<=0; no new fetch. pc holds.
//   BOOT: no load; if_id_valid stays 0. A redirect in BOOT is taken and state -> RUN.
//   Latency: address-to-IF/ID 1 cycle; steady state 1 instr/cycle when id_ready=1.
//   PC wraps 32'hFFFF_FFFC -> 0 (only reachable if MEM_DEPTH covers it).
//   Reset mid-stall or mid-redirect: all state to reset values, no partial update.
// STRUCTURE
//   Shared package/header: NOP_INSTR=32'h0000_0000, fetch state encodings
//     (BOOT=2'd0, RUN=2'd1, HALTED=2'd2), 32-bit XLEN width constant.
//   One sub-module: if_id_reg (load/flush/hold pipeline register for instr, pc, pc4, valid);
//     PC, FSM, counter stay in fetch_unit.
// TESTING
//   1 Reset release, id_ready=1, mem[0..3]=A,B,C,D -> cycle1 BOOT no valid; then IF/ID gets
//     A@0, B@4, C@8, D@12 on consecutive cycles; fetch_count=4.
//   2 id_ready=0 for 3 cycles holding B@4 -> pc=8, IF/ID bit-exact stable; release -> C@8 next.
//   3 redirect_valid with redirect_pc=32'h0000_0041 while stalled -> next cycle if_id_valid=0,
//     pc=32'h40; following cycle IF/ID = mem[16]@0x40.
//   4 MEM_DEPTH=4, run straight -> after D@12, pc=16 out of range: if_id_valid=0, halted=1,
//     fetch_count stays 4; redirect to 0 -> RUN, A@0 delivered again.
//   5 Assert reset asynchronously mid-stream (between edges) -> outputs zero immediately,
//     pc=RESET_PC; fetch resumes with BOOT cycle after release.
//   6 Same-cycle redirect and id_ready with valid IF/ID -> old entry consumed, flush wins,
//     no wrong-path word ever has if_id_valid=1.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, flush to NOP, or hold.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_vld_p1,
    output logic [XLEN-1:0] o_instr_p1,
    output logic [XLEN-1:0] o_pc_p1,
    output logic [XLEN-1:0] o_pc4_p1
);

    logic            r_vld_p1;
    logic [XLEN-1:0] r_instr_p1;
    logic [XLEN-1:0] r_pc_p1;
    logic [XLEN-1:0] r_pc4_p1;

    // IF -> ID boundary; flush leaves pc/pc4 untouched since only valid and instr matter downstream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1   <= 1'b0;
            r_instr_p1 <= NOP_INSTR;
            r_pc_p1    <= '0;
            r_pc4_p1   <= '0;
        end else if (i_flush) begin
            r_vld_p1   <= 1'b0;
            r_instr_p1 <= NOP_INSTR;
        end else if (i_load) begin
            r_vld_p1   <= 1'b1;
            r_instr_p1 <= i_instr;
            r_pc_p1    <= i_pc;
            r_pc4_p1   <= i_pc + 32'd4;
        end
    end

    assign o_vld_p1   = r_vld_p1;
    assign o_instr_p1 = r_instr_p1;
    assign o_pc_p1    = r_pc_p1;
    assign o_pc4_p1   = r_pc4_p1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, boot/run/halt control, delivered-instruction counter, IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     MEM_DEPTH = 256
)
(
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic            halted,
    output logic [XLEN-1:0] fetch_count
);

    localparam logic [XLEN-1:0] DEPTH_W = XLEN'(MEM_DEPTH);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] r_fetch_count;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_advance;
    logic            w_in_range;
    logic            w_load;
    logic            w_flush;
    logic            w_count_inc;
    logic            w_vld_p1;

    assign w_advance  = !w_vld_p1 || id_ready;
    assign w_in_range = (r_pc >> 2) < DEPTH_W;
    assign w_redir_pc = redirect_pc & ~32'h0000_0003;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_BOOT;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_BOOT:   w_state_next = ST_RUN;
                ST_RUN:    if (w_advance && !w_in_range) w_state_next = ST_HALTED;
                ST_HALTED: w_state_next = ST_HALTED;
                default:   w_state_next = ST_BOOT;
            endcase
        end
    end

    // Redirect beats everything; a halted stage only flushes once decode has taken its last word
    always_comb begin
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_count_inc = 1'b0;
        w_pc_next   = r_pc;
        if (redirect_valid) begin
            w_flush   = 1'b1;
            w_pc_next = w_redir_pc;
        end else if (r_state == ST_RUN && w_advance) begin
            if (w_in_range) begin
                w_load      = 1'b1;
                w_count_inc = 1'b1;
                w_pc_next   = r_pc + 32'd4;
            end else begin
                w_flush = 1'b1;
            end
        end else if (r_state == ST_HALTED && w_advance) begin
            w_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pc <= RESET_PC;
        else       r_pc <= w_pc_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_fetch_count <= '0;
        else if (w_count_inc && r_fetch_count != 32'hFFFF_FFFF)
            r_fetch_count <= r_fetch_count + 32'd1;
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_flush    (w_flush),
        .i_instr    (imem_data),
        .i_pc       (r_pc),
        .o_vld_p1   (w_vld_p1),
        .o_instr_p1 (if_id_instr),
        .o_pc_p1    (if_id_pc),
        .o_pc4_p1   (if_id_pc4)
    );

    assign if_id_valid = w_vld_p1;
    assign imem_addr   = r_pc;
    assign halted      = (r_state == ST_HALTED);
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a full-size instance plus a MEM_DEPTH=4 instance for halting.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem [0:255];

    logic [31:0] imem_addr, imem_data, redirect_pc;
    logic        redirect_valid, id_ready;
    logic        if_id_valid, halted;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc4, fetch_count;

    logic [31:0] imem_addr4, imem_data4, redirect_pc4;
    logic        redirect_valid4, id_ready4;
    logic        if_id_valid4, halted4;
    logic [31:0] if_id_instr4, if_id_pc_4, if_id_pc4_4, fetch_count4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_data  = mem[imem_addr[9:2]];
    assign imem_data4 = mem[imem_addr4[9:2]];

    fetch_unit #(.RESET_PC(32'h0), .MEM_DEPTH(256)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc4(if_id_pc4), .halted(halted), .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_PC(32'h0), .MEM_DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .imem_addr(imem_addr4), .imem_data(imem_data4),
        .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4), .id_ready(id_ready4),
        .if_id_valid(if_id_valid4), .if_id_instr(if_id_instr4), .if_id_pc(if_id_pc_4),
        .if_id_pc4(if_id_pc4_4), .halted(halted4), .fetch_count(fetch_count4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        check({tag, "_instr"}, if_id_instr, 32'h0);
        check({tag, "_pc"},    if_id_pc,    32'h0);
        check({tag, "_pc4"},   if_id_pc4,   32'h0);
        check({tag, "_halt"},  {31'd0, halted}, 32'd0);
        check({tag, "_cnt"},   fetch_count, 32'd0);
        check({tag, "_addr"},  imem_addr,   32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i)};
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        redirect_valid4 = 1'b0; redirect_pc4 = '0; id_ready4 = 1'b1;

        #2 reset = 1'b1;
        #1 check_zero("rst");
        tick();
        reset = 1'b0;

        tick();
        check("boot_valid", {31'd0, if_id_valid}, 32'd0);
        check("boot_addr", imem_addr, 32'h0);
        tick();
        check("a_valid", {31'd0, if_id_valid}, 32'd1);
        check("a_instr", if_id_instr, 32'hC0DE_0000);
        check("a_pc", if_id_pc, 32'h0);
        check("a_pc4", if_id_pc4, 32'h4);
        check("a_cnt", fetch_count, 32'd1);
        tick();
        check("b_instr", if_id_instr, 32'hC0DE_0001);
        check("b_pc", if_id_pc, 32'h4);

        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", {31'd0, if_id_valid}, 32'd1);
            check("stall_instr", if_id_instr, 32'hC0DE_0001);
            check("stall_pc", if_id_pc, 32'h4);
            check("stall_pc4", if_id_pc4, 32'h8);
            check("stall_addr", imem_addr, 32'h8);
            check("stall_cnt", fetch_count, 32'd2);
        end
        id_ready = 1'b1;
        tick();
        check("c_instr", if_id_instr, 32'hC0DE_0002);
        check("c_pc", if_id_pc, 32'h8);
        tick();
        check("d_instr", if_id_instr, 32'hC0DE_0003);
        check("d_pc", if_id_pc, 32'hC);
        check("d_cnt", fetch_count, 32'd4);

        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0041;
        tick();
        check("redir_valid", {31'd0, if_id_valid}, 32'd0);
        check("redir_instr", if_id_instr, 32'h0);
        check("redir_addr", imem_addr, 32'h40);
        redirect_valid = 1'b0;
        tick();
        check("r16_valid", {31'd0, if_id_valid}, 32'd1);
        check("r16_instr", if_id_instr, 32'hC0DE_0010);
        check("r16_pc", if_id_pc, 32'h40);
        check("r16_pc4", if_id_pc4, 32'h44);
        check("r16_cnt", fetch_count, 32'd5);

        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0008;
        tick();
        check("sameflush_valid", {31'd0, if_id_valid}, 32'd0);
        check("sameflush_addr", imem_addr, 32'h8);
        check("sameflush_cnt", fetch_count, 32'd5);
        redirect_valid = 1'b0;
        tick();
        check("post_instr", if_id_instr, 32'hC0DE_0002);
        check("post_pc", if_id_pc, 32'h8);
        check("post_cnt", fetch_count, 32'd6);

        #2 reset = 1'b1;
        #1 check_zero("arst");
        tick();
        reset = 1'b0;
        tick();
        check("reboot_valid", {31'd0, if_id_valid}, 32'd0);
        check("reboot_halt4", {31'd0, halted4}, 32'd0);
        check("reboot_cnt4", fetch_count4, 32'd0);
        tick();
        check("rea_instr", if_id_instr, 32'hC0DE_0000);
        check("rea_valid", {31'd0, if_id_valid}, 32'd1);
        check("d4a_instr", if_id_instr4, 32'hC0DE_0000);
        tick(); tick(); tick();
        check("d4d_instr", if_id_instr4, 32'hC0DE_0003);
        check("d4d_pc", if_id_pc_4, 32'hC);
        check("d4d_cnt", fetch_count4, 32'd4);
        tick();
        check("halt_valid", {31'd0, if_id_valid4}, 32'd0);
        check("halt_instr", if_id_instr4, 32'h0);
        check("halt_flag", {31'd0, halted4}, 32'd1);
        check("halt_cnt", fetch_count4, 32'd4);
        check("halt_addr", imem_addr4, 32'h10);
        tick();
        check("halt2_flag", {31'd0, halted4}, 32'd1);
        check("halt2_valid", {31'd0, if_id_valid4}, 32'd0);
        check("halt2_cnt", fetch_count4, 32'd4);

        redirect_valid4 = 1'b1; redirect_pc4 = 32'h0;
        tick();
        check("unhalt_flag", {31'd0, halted4}, 32'd0);
        check("unhalt_addr", imem_addr4, 32'h0);
        check("unhalt_valid", {31'd0, if_id_valid4}, 32'd0);
        redirect_valid4 = 1'b0;
        tick();
        check("again_valid", {31'd0, if_id_valid4}, 32'd1);
        check("again_instr", if_id_instr4, 32'hC0DE_0000);
        check("again_pc", if_id_pc_4, 32'h0);
        check("again_cnt", fetch_count4, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
